// File: rtl/t3_pkg.sv
// Shared definitions for the ternary core: trit codes, word geometry and the
// program-counter state type.
package t3_pkg;

    localparam logic [1:0] T3_ZERO = 2'b00;
    localparam logic [1:0] T3_POS  = 2'b01;
    localparam logic [1:0] T3_NEG  = 2'b10;
    localparam logic [1:0] T3_BAD  = 2'b11;

    localparam int unsigned T3_TRITS  = 16;
    localparam int unsigned T3_WORD_W = 2 * T3_TRITS;

    typedef enum logic [1:0] {
        PC_RESET,
        PC_RUN,
        PC_HALTED,
        PC_ERROR
    } t3_pc_state_t;

endpackage

// File: rtl/t3_increment.sv
// Balanced-ternary +1 with a ripple carry; the carry out of the top trit is
// dropped, so the maximum word wraps to the minimum.
module t3_increment
    import t3_pkg::*;
(
    input  logic [T3_WORD_W-1:0] I_word,
    output logic [T3_WORD_W-1:0] O_word
);

    logic carry;

    always_comb begin
        O_word = I_word;
        carry  = 1'b1;
        for (int unsigned i = 0; i < T3_TRITS; i++) begin
            if (carry) begin
                unique case (I_word[2*i +: 2])
                    T3_ZERO: begin
                        O_word[2*i +: 2] = T3_POS;
                        carry            = 1'b0;
                    end
                    T3_POS: begin
                        O_word[2*i +: 2] = T3_NEG;
                        carry            = 1'b1;
                    end
                    T3_NEG: begin
                        O_word[2*i +: 2] = T3_ZERO;
                        carry            = 1'b0;
                    end
                    default: begin
                        carry = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/t3_word_check.sv
// Flags a balanced-ternary word that contains any illegal trit code.
module t3_word_check
    import t3_pkg::*;
(
    input  logic [T3_WORD_W-1:0] I_word,
    output logic                 O_bad
);

    always_comb begin
        O_bad = 1'b0;
        for (int unsigned i = 0; i < T3_TRITS; i++) begin
            if (I_word[2*i +: 2] == T3_BAD) begin
                O_bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t3_pc_sequencer.sv
// Program-counter stage: offers the current balanced-ternary PC to fetch over
// valid/ready, advances it on each accepted transfer, and takes redirects/halts.
module t3_pc_sequencer
    import t3_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_ready,
    input  logic        I_redirect,
    input  logic [31:0] I_target,
    input  logic        I_halt,
    output logic [31:0] O_pc,
    output logic        O_valid,
    output logic        O_error,
    output logic [15:0] O_count
);

    t3_pc_state_t state;
    logic [31:0]  pc_inc;
    logic         target_bad;
    logic         fire;

    t3_increment u_increment (
        .I_word (O_pc),
        .O_word (pc_inc)
    );

    t3_word_check u_target_check (
        .I_word (I_target),
        .O_bad  (target_bad)
    );

    assign fire = O_valid && I_ready;

    // O_valid/O_error are registered alongside the state they describe.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state   <= PC_RESET;
            O_pc    <= RESET_PC;
            O_valid <= 1'b0;
            O_error <= 1'b0;
            O_count <= '0;
        end else begin
            unique case (state)
                PC_RESET: begin
                    state   <= PC_RUN;
                    O_valid <= 1'b1;
                end
                PC_RUN, PC_HALTED: begin
                    if (I_redirect && target_bad) begin
                        state   <= PC_ERROR;
                        O_valid <= 1'b0;
                        O_error <= 1'b1;
                    end else if (I_redirect) begin
                        state   <= PC_RUN;
                        O_pc    <= I_target;
                        O_valid <= 1'b1;
                    end else begin
                        // A fire in the same cycle as a halt still completes.
                        if (fire) begin
                            O_pc    <= pc_inc;
                            O_count <= O_count + 16'd1;
                        end
                        if (I_halt && state == PC_RUN) begin
                            state   <= PC_HALTED;
                            O_valid <= 1'b0;
                        end
                    end
                end
                PC_ERROR: begin
                    O_valid <= 1'b0;
                    O_error <= 1'b1;
                end
                default: begin
                    state   <= PC_ERROR;
                    O_valid <= 1'b0;
                    O_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t3_pc_sequencer.sv
// Scoreboard bench for t3_pc_sequencer: an integer-valued balanced-ternary
// reference model predicts each edge; a monitor compares after every edge.
module tb_t3_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAXV     = 21523360;  // (3^16 - 1) / 2

    logic        clk;
    logic        rst;
    logic        ready;
    logic        redirect;
    logic [31:0] target;
    logic        halt;
    logic [31:0] pc;
    logic        valid;
    logic        err;
    logic [15:0] cnt;

    t3_pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .I_clk      (clk),
        .I_reset    (rst),
        .I_ready    (ready),
        .I_redirect (redirect),
        .I_target   (target),
        .I_halt     (halt),
        .O_pc       (pc),
        .O_valid    (valid),
        .O_error    (err),
        .O_count    (cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    int          m_pc;
    bit          m_live;
    bit          m_halted;
    bit          m_err;
    int unsigned m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic int w2i(input logic [31:0] w);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 16; i++) begin
            if (w[2*i +: 2] == 2'b01) v += p;
            else if (w[2*i +: 2] == 2'b10) v -= p;
            p *= 3;
        end
        return v;
    endfunction

    function automatic logic [31:0] i2w(input int v);
        logic [31:0] w = '0;
        int r = v;
        int d;
        for (int i = 0; i < 16; i++) begin
            d = r % 3;
            if (d == 2) d = -1;
            if (d == -2) d = 1;
            w[2*i +: 2] = (d == 1) ? 2'b01 : (d == -1) ? 2'b10 : 2'b00;
            r = (r - d) / 3;
        end
        return w;
    endfunction

    function automatic bit illegal(input logic [31:0] w);
        for (int i = 0; i < 16; i++)
            if (w[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 16; i++) w[2*i +: 2] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    task automatic model_reset();
        m_pc     = w2i(RESET_PC);
        m_live   = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    // Apply inputs for one edge, predict the outcome, then step to the next negedge.
    task automatic drive(input logic r, input logic rd, input logic [31:0] t, input logic h);
        exp_t e;
        bit   offering;
        ready    = r;
        redirect = rd;
        target   = t;
        halt     = h;
        offering = m_live && !m_halted && !m_err;
        if (m_err) begin
        end else if (!m_live) begin
            m_live = 1'b1;
        end else if (rd && illegal(t)) begin
            m_err = 1'b1;
        end else if (rd) begin
            m_pc     = w2i(t);
            m_halted = 1'b0;
        end else begin
            if (offering && r) begin
                m_pc  = (m_pc == MAXV) ? -MAXV : m_pc + 1;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (h) m_halted = 1'b1;
        end
        e.pc    = i2w(m_pc);
        e.valid = m_live && !m_halted && !m_err;
        e.err   = m_err;
        e.cnt   = 16'(m_cnt);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (pc !== mon_e.pc || valid !== mon_e.valid || err !== mon_e.err || cnt !== mon_e.cnt) begin
                errors++;
                $display("FAIL edge@%0t: got pc=%h valid=%b err=%b count=%0d, want pc=%h valid=%b err=%b count=%0d",
                         $time, pc, valid, err, cnt, mon_e.pc, mon_e.valid, mon_e.err, mon_e.cnt);
            end
        end
    end

    task automatic peek(input string nm, input logic [31:0] ep, input logic ev, input logic ee);
        checks++;
        if (pc !== ep || valid !== ev || err !== ee) begin
            errors++;
            $display("FAIL %s: got pc=%h valid=%b err=%b, want pc=%h valid=%b err=%b",
                     nm, pc, valid, err, ep, ev, ee);
        end
    endtask

    task automatic check_reset_values(input string nm);
        checks++;
        if (pc !== RESET_PC || valid !== 1'b0 || err !== 1'b0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s: got pc=%h valid=%b err=%b count=%0d, want pc=%h valid=0 err=0 count=0",
                     nm, pc, valid, err, cnt, RESET_PC);
        end
    endtask

    // Assert reset between edges, check it acts at once, release at a negedge.
    task automatic do_reset(input string nm);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values(nm);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit          r, rd, h;
        logic [31:0] t;

        rst      = 1'b1;
        ready    = 1'b0;
        redirect = 1'b0;
        target   = '0;
        halt     = 1'b0;
        #2;
        check_reset_values("power_on_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Sequential run from reset, stall at 0x6, resume.
        drive(1, 0, 0, 0);
        peek("first_offer", 32'h0, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        peek("seq_pc6", 32'h6, 1, 0);
        repeat (3) drive(0, 0, 0, 0);
        peek("stall_hold", 32'h6, 1, 0);
        drive(1, 0, 0, 0);
        peek("stall_release", 32'h4, 1, 0);
        drive(1, 0, 0, 0);

        // Redirects, carry ripple and wrap.
        drive(1, 1, 32'h1555_5555, 0);
        peek("redirect_target", 32'h1555_5555, 1, 0);
        drive(1, 0, 0, 0);
        peek("carry_ripple", 32'h6AAA_AAAA, 1, 0);
        drive(1, 1, 32'h5555_5555, 0);
        drive(1, 0, 0, 0);
        peek("wrap_max_min", 32'hAAAA_AAAA, 1, 0);

        // Halt/redirect interplay.
        drive(0, 1, 32'h0000_0040, 1);
        peek("redirect_beats_halt", 32'h40, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(0, 1, 32'h0, 0);
        peek("resume_from_halt", 32'h0, 1, 0);

        // Illegal redirect is sticky until reset.
        drive(1, 1, 32'h0000_0003, 0);
        peek("illegal_redirect", 32'h0, 0, 1);
        drive(1, 1, 32'h0000_0001, 0);
        drive(1, 0, 0, 0);
        do_reset("reset_clears_error");

        // Reset during a stalled offer.
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        do_reset("reset_mid_stall");
        drive(1, 0, 0, 0);
        peek("valid_after_release", RESET_PC, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if (m_err && ($urandom % 4 == 0)) begin
                do_reset("rand_reset_err");
            end else if ($urandom % 400 == 0) begin
                do_reset("rand_reset");
            end else begin
                r  = ($urandom % 4) != 0;
                rd = ($urandom % 8) == 0;
                h  = ($urandom % 10) == 0;
                t  = ($urandom % 3 == 0) ? 32'h5555_5555 - 32'(($urandom % 2) * 32'h4) : rand_word();
                if (rd && ($urandom % 10 == 0)) t[2*($urandom % 16) +: 2] = 2'b11;
                drive(r, rd, t, h);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t3_pc_sequencer.md
# t3_pc_sequencer

Program-counter stage for the ternary core: holds the current 16-trit balanced-ternary PC, presents it to fetch over a valid/ready handshake, and advances it through an instantiated `t3_increment` on every accepted transfer. Control flow enters via a redirect port (branch/jump target) and a halt request. It is the sole consumer of `t3_increment` in the fetch path.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset (balanced-ternary word, 16 trits × 2 bits).
- `I_clk` input 1: clock, rising edge.
- `I_reset` input 1: asynchronous, active-high reset.
- `I_ready` input 1: fetch accepts `O_pc` this cycle.
- `I_redirect` input 1: load `I_target` as next PC.
- `I_target` input 32: redirect target, balanced-ternary word.
- `I_halt` input 1: stop issuing after current cycle.
- `O_pc` output 32: current PC.
- `O_valid` output 1: `O_pc` is offered to fetch.
- `O_error` output 1: sticky; an illegal trit code was received on a redirect.
- `O_count` output 16: binary count of accepted transfers, wraps modulo 2^16.

## Operation
- Trit encoding: 00 = 0, 01 = +1, 10 = −1, 11 = illegal. Trit 0 is in bits [1:0].
- Next sequential PC = `t3_increment(O_pc)`, combinational. The carry out of trit 15 is dropped: 0x5555_5555 (max) wraps to 0xAAAA_AAAA (min).
- FSM states: RESET, RUN, HALTED, ERROR.
  - RESET: `O_valid` = 0. Next edge goes to RUN.
  - RUN: `O_valid` = 1. A fire is `O_valid && I_ready`.
  - HALTED: `O_valid` = 0, PC held.
  - ERROR: `O_valid` = 0, `O_error` = 1. Only `I_reset` leaves this state.
- Per-edge priority in RUN and HALTED, highest first:
  1. `I_redirect` with an illegal target (any trit = 11) → ERROR. PC unchanged.
  2. `I_redirect` with a legal target → PC = `I_target`, state → RUN. This also resumes from HALTED. A concurrent `I_halt` is ignored.
  3. `I_halt` (RUN only) → HALTED. If the same cycle fires, PC still advances and `O_count` increments first.
  4. Fire → PC = increment(PC), `O_count`++.
  5. Otherwise hold PC. A stalled offer (`O_valid && !I_ready`) keeps `O_pc` stable until it fires or is redirected.
- Redirect during a stalled offer abandons that offer: it is not counted and `O_pc` changes.
- `I_ready` is ignored when `O_valid` = 0. `I_halt` in HALTED is a no-op.
- `O_count` counts only fires. It does not count redirects.

## Timing
- Reset values, applied asynchronously: `O_pc` = `RESET_PC`, `O_valid` = 0, `O_error` = 0, `O_count` = 0, state = RESET.
- First edge after reset release: state → RUN. `O_valid` = 1 from that cycle on, with `O_pc` = `RESET_PC`.
- All outputs are registered. The increment path is combinational, register to register, and must close timing within one cycle.
- Latencies, each taking one edge:
  - Fire → next PC visible.
  - Redirect → target visible with `O_valid` = 1.
  - Halt → `O_valid` = 0.
- Reset asserted mid-operation: outputs return to their reset values immediately, without waiting for a clock edge.
- Back-to-back fires with `I_ready` held at 1: a new PC every cycle, no bubbles.

## Structure
- Shared package `t3_pkg` holds:
  - trit code constants `T3_ZERO`, `T3_POS`, `T3_NEG`, `T3_BAD`;
  - `T3_TRITS` = 16;
  - the `t3_pc_state_t` enum. `t3_increment` moves to these constants too.
- Sub-modules:
  - Instantiates the existing `t3_increment` unchanged.
  - One new sub-module, `t3_word_check`: combinational; outputs 1 if any trit of a 32-bit word is 11. It is reusable by the ALU stages.

## Test plan
- Reset release with `I_ready` = 1 → cycle 1: `O_pc` = 0x0000_0000, `O_valid` = 1. Following cycles: 0x1, 0x6, 0x4, 0x5; `O_count` = 1, 2, 3, 4.
- Stall: hold `I_ready` = 0 for 3 cycles at PC 0x6 → `O_pc` stays 0x6 and `O_count` is unchanged. Raise `I_ready` → the next cycle shows 0x4.
- Redirect to 0x1555_5555 → next `O_pc` = 0x1555_5555. After one fire: 0x6AAA_AAAA. Redirect to 0x5555_5555 and fire → 0xAAAA_AAAA.
- `I_halt` and `I_redirect` (target 0x0000_0040) in the same cycle → RUN at 0x40. Later `I_halt` alone → `O_valid` = 0 next cycle with PC held. Redirect to 0x0 → resumes with `O_valid` = 1.
- Redirect to 0x0000_0003 (illegal trit) → `O_error` = 1 and `O_valid` = 0. Both stay sticky through a further legal redirect. `I_reset` clears them asynchronously.
- Assert `I_reset` mid-stall (between edges) → `O_pc` = `RESET_PC` and `O_count` = 0 immediately. `O_valid` returns one edge after release.
